// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES InvSubBytes engine, LANES bytes per cycle
//
// Accepts a 128-bit AES state on in_valid/in_ready, substitutes every byte through
// the inverse S-box over 16/LANES BUSY cycles, then holds the result on
// out_valid/out_ready until it is taken.
//
// Parameters:
//   LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input block available
//   in_ready   engine idle and able to accept
//   state_in   input state, byte k at [127-8k -: 8]
//   out_valid  finished block on state_out
//   out_ready  downstream takes state_out
//   state_out  substituted state, same byte order
//   fwd        (INV_SUB_BYTES_FWD_EN only) 1 = forward S-box for this block
//
// Optional feature macro: INV_SUB_BYTES_FWD_EN adds the fwd port and forward S-box.

module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
`ifdef INV_SUB_BYTES_FWD_EN
    ,
    input  logic         fwd
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_data;
    logic [3:0]     r_idx;
    logic [127:0]   w_sub;
    logic           w_last;
`ifdef INV_SUB_BYTES_FWD_EN
    logic           r_fwd;
`endif

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    // Field inversion followed by the forward affine transform.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction
`endif

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic use_fwd);
`ifdef INV_SUB_BYTES_FWD_EN
        return use_fwd ? fwd_sbox(b) : inv_sbox(b);
`else
        if (use_fwd) return inv_sbox(b);
        return inv_sbox(b);
`endif
    endfunction

    logic w_mode_fwd;
`ifdef INV_SUB_BYTES_FWD_EN
    assign w_mode_fwd = r_fwd;
`else
    assign w_mode_fwd = 1'b0;
`endif

    // LANES parallel substitutions on bytes r_idx .. r_idx+LANES-1.
    always_comb begin
        w_sub = r_data;
        for (int l = 0; l < LANES; l++) begin
            logic [3:0] pos;
            int         bit_lo;
            pos    = r_idx + 4'(l);
            bit_lo = 8 * (15 - int'(pos));
            w_sub[bit_lo +: 8] = sub_byte(r_data[bit_lo +: 8], w_mode_fwd);
        end
    end

    // Final BUSY cycle is the one covering the last LANES bytes.
    assign w_last = (({1'b0, r_idx} + 5'(LANES)) == 5'd16);

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= 128'h0;
            r_idx   <= 4'h0;
`ifdef INV_SUB_BYTES_FWD_EN
            r_fwd   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= state_in;
                        r_idx  <= 4'h0;
`ifdef INV_SUB_BYTES_FWD_EN
                        r_fwd  <= fwd;
`endif
                    end
                end
                S_BUSY: begin
                    r_data <= w_sub;
                    // Hold idx on the last step so it never wraps on its own.
                    if (!w_last) r_idx <= r_idx + 4'(LANES);
                end
                default: ;
            endcase
        end
    end

    assign state_out = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - self-checking bench for inv_sub_bytes_iter (LANES 4, 1, 16)

module tb_inv_sub_bytes_iter;

    logic         clk;
    logic         rst;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] state_in_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] state_out_a [3];
    logic         fwd_a       [3];

    int lanes_of [3] = '{4, 1, 16};

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .state_in(state_in_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .state_out(state_out_a[0])
`ifdef INV_SUB_BYTES_FWD_EN
        , .fwd(fwd_a[0])
`endif
    );

    inv_sub_bytes_iter #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .state_in(state_in_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .state_out(state_out_a[1])
`ifdef INV_SUB_BYTES_FWD_EN
        , .fwd(fwd_a[1])
`endif
    );

    inv_sub_bytes_iter #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .state_in(state_in_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .state_out(state_out_a[2])
`ifdef INV_SUB_BYTES_FWD_EN
        , .fwd(fwd_a[2])
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int sh);
        logic [15:0] d;
        d = {x, x} << sh;
        return d[15:8];
    endfunction

    // Forward S-box by walking the multiplicative group with generator 3 and
    // its inverse, then inverting the table.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            ref_fwd[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        ref_fwd[0] = 8'h63;
        for (int i = 0; i < 256; i++) ref_inv[ref_fwd[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic f);
        logic [127:0] r;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            r[127-8*k -: 8] = f ? ref_fwd[b] : ref_inv[b];
        end
        return r;
    endfunction

    // Called at a negedge with instance i idle; returns once out_valid seen or bound hit.
    task automatic send_block(input int i, input logic [127:0] data, input logic f,
                              input string tag);
        int lat;
        in_valid_a[i] = 1'b1;
        state_in_a[i] = data;
        fwd_a[i]      = f;
        @(negedge clk);
        in_valid_a[i] = 1'b0;
        state_in_a[i] = {$urandom, $urandom, $urandom, $urandom};
        fwd_a[i]      = ~f;
        check({tag, "_busy_in_ready"}, 128'(in_ready_a[i]), 128'd0);
        lat = 0;
        while (!out_valid_a[i] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(16 / lanes_of[i]));
`ifdef INV_SUB_BYTES_FWD_EN
        check({tag, "_data"}, state_out_a[i], model(data, f));
`else
        check({tag, "_data"}, state_out_a[i], model(data, 1'b0));
`endif
    endtask

    task automatic release_block(input int i, input string tag);
        out_ready_a[i] = 1'b1;
        @(negedge clk);
        out_ready_a[i] = 1'b0;
        check({tag, "_rel_out_valid"}, 128'(out_valid_a[i]), 128'd0);
        check({tag, "_rel_in_ready"}, 128'(in_ready_a[i]), 128'd1);
    endtask

    initial begin
        logic [7:0]   perm [256];
        logic [127:0] blk;
        logic [127:0] held;
        logic [7:0]   t;
        int           j;

        build_tables();
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            state_in_a[i]  = '0;
            out_ready_a[i] = 1'b0;
            fwd_a[i]       = 1'b0;
        end

        // Reset for two cycles then check the idle state of every instance.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_in_ready", 128'(in_ready_a[i]), 128'd1);
            check("reset_out_valid", 128'(out_valid_a[i]), 128'd0);
            check("reset_state_out", state_out_a[i], 128'h0);
        end

        // Known vector on the LANES=4 instance, constant expectation.
        send_block(0, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0, "basic");
        check("basic_const", state_out_a[0], 128'h000102030405060708090a0b0c0d0e0f);
        release_block(0, "basic");

        // Directed boundary bytes with constant expectation on every instance.
        for (int i = 0; i < 3; i++) begin
            send_block(i, 128'h52ed16637c0063636363636363636363, 1'b0, "spot");
            check("spot_const", state_out_a[i], 128'h4853ff00015200000000000000000000);
            release_block(i, "spot");
        end

        // Every byte value once per instance, in a random order.
        for (int k = 0; k < 256; k++) perm[k] = 8'(k);
        for (int k = 255; k > 0; k--) begin
            j = int'($urandom_range(k, 0));
            t = perm[k];
            perm[k] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 16; b++) begin
                for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = perm[16*b + k];
                send_block(i, blk, 1'b0, "cover");
                release_block(i, "cover");
            end
        end

        // Fully random blocks.
        for (int n = 0; n < 6; n++) begin
            send_block(n % 3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "rand");
            release_block(n % 3, "rand");
        end

        // Backpressure: hold out_ready low, pulse in_valid, result must not move.
        send_block(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "bp");
        held = state_out_a[0];
        for (int c = 0; c < 10; c++) begin
            in_valid_a[0] = c[0];
            state_in_a[0] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
            check("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
            check("bp_stable", state_out_a[0], held);
        end
        in_valid_a[0] = 1'b0;
        release_block(0, "bp");

        // out_ready while idle has no effect.
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        check("idle_ready_in_ready", 128'(in_ready_a[0]), 128'd1);
        check("idle_ready_out_valid", 128'(out_valid_a[0]), 128'd0);

        // Reset during the second BUSY cycle of the LANES=4 instance.
        in_valid_a[0] = 1'b1;
        state_in_a[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(in_ready_a[0]), 128'd1);
        check("midrst_out_valid", 128'(out_valid_a[0]), 128'd0);
        check("midrst_state_out", state_out_a[0], 128'h0);
        send_block(0, 128'h0, 1'b0, "after_rst");
        check("after_rst_const", state_out_a[0], {16{8'h52}});
        release_block(0, "after_rst");

`ifdef INV_SUB_BYTES_FWD_EN
        // Forward mode, then the inverse on the result.
        send_block(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, "fwd");
        check("fwd_const", state_out_a[0], 128'h637c777bf26b6fc53001672bfed7ab76);
        held = state_out_a[0];
        release_block(0, "fwd");
        send_block(0, held, 1'b0, "fwd_back");
        check("fwd_back_const", state_out_a[0], 128'h000102030405060708090a0b0c0d0e0f);
        release_block(0, "fwd_back");
        for (int n = 0; n < 6; n++) begin
            send_block(n % 3, {$urandom, $urandom, $urandom, $urandom}, n[0], "fwd_rand");
            release_block(n % 3, "fwd_rand");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative AES InvSubBytes engine for the decryption datapath: accepts a 128-bit state over a valid/ready handshake, applies the inverse S-box to all 16 bytes over 16/LANES cycles, and presents the result on a held valid/ready output. It is the decrypt-side counterpart of the forward byte-substitution lookup and sits between InvShiftRows and AddRoundKey in the inverse round. A compile-time option adds a per-block forward-substitution mode.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in holds a block to process
- in_ready  output  1  high only in IDLE
- state_in  input  128  input state; byte k = state_in[127-8k -: 8], k = 0..15 (FIPS-197 order)
- out_valid  output  1  state_out holds a finished block
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  substituted state; same byte order
- fwd  input  1  only with INV_SUB_BYTES_FWD_EN; sampled on accept

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, register state_in into the working register, clear byte counter idx to 0, go BUSY. in_valid ignored in every other state.
- BUSY: each cycle, replace bytes idx .. idx+LANES-1 with InvSbox(byte); idx += LANES. On the cycle where idx+LANES = 16, go DONE.
- DONE: out_valid=1, state_out = working register, held stable. On out_ready go IDLE. No new accept in the DONE cycle.
- InvSbox is the exact inverse of the AES S-box (e.g. 0x63->0x00, 0x7c->0x01, 0x16->0xff, 0x00->0x52, 0x52->0x48, 0xed->0x53). Implementation choice (256-entry table or inverse affine + GF(2^8) inversion) is free; LANES parallel instances.
- state_in may change after the accepting edge without effect.
- Reset mid-operation (BUSY or DONE): discard block, go IDLE, out_valid=0.
- idx width = 4 bits; wraps only via reset to 0 on accept.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, state_out=128'h0, idx=0.
- N = 16/LANES. Accepting edge E0; out_valid rises after edge EN (N edges later). LANES=4 -> 4 cycles; LANES=16 -> 1.
- out_valid high with out_ready high: IDLE after the next edge; in_ready high one cycle after the handshake cycle.
- Minimum block period: N+2 cycles.
- out_ready held low: out_valid and state_out stay constant indefinitely.
- out_ready in cycles where out_valid=0: no effect.

## Configuration
- INV_SUB_BYTES_FWD_EN defined: port fwd present; fwd registered on accept; fwd=1 applies forward S-box (0x00->0x63, 0x53->0xed) to all bytes of that block, fwd=0 applies InvSbox. Timing identical in both modes.
- Not defined: no fwd port, no forward table; always InvSbox.

## Test plan
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, state_out=0 after release.
- Basic vector, LANES=4: state_in=637c777bf26b6fc53001672bfed7ab76, single accept -> out_valid exactly 4 edges later, state_out=000102030405060708090a0b0c0d0e0f.
- All-byte coverage: 16 blocks covering input bytes 0x00..0xff -> each byte matches InvSbox (e.g. 0x52->0x48, 0xed->0x53, 0x16->0xff); LANES=1 and 16 both checked (latency 16 and 1).
- Backpressure: out_ready low 10 cycles after out_valid -> state_out stable, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 one cycle later.
- Reset mid-BUSY: rst asserted in second BUSY cycle -> next cycle IDLE, out_valid=0; next block 00..00 returns 52..52.
- With INV_SUB_BYTES_FWD_EN: fwd=1, state_in=000102030405060708090a0b0c0d0e0f -> state_out=637c777bf26b6fc53001672bfed7ab76; fwd=0 back-to-back inverts it.
